// File: rtl/logic_arb_pkg.sv
// Shared definitions for the logic-unit arbiter: op encoding, FSM states,
// datapath width and a one-bit evaluation helper for the logic unit.
package logic_arb_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  // Evaluate one result bit; every op is purely bitwise, so bits are independent.
  function automatic logic logic_bit(input op_e op, input logic a, input logic b);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_32.sv
// Combinational 32-bit bitwise logic unit (AND/OR/XOR/NOR) with zero flag.
// Built as one slice per bit since no bit depends on its neighbours.
module logic_unit_32
  import logic_arb_pkg::*;
(
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign result[gi] = logic_bit(op_e'(op), a[gi], b[gi]);
    end
  endgenerate

  assign zero = ~|result;

endmodule

// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter owning a shared bitwise logic unit.
// Sequence per operation: IDLE (accept) -> EXEC (compute, register result)
// -> RESP (hold until consumer handshake).
// Build option: define LOGIC_ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// otherwise requester 0 always wins ties and no last-grant register exists.
// Only WIDTH = 32 is supported.
module logic_unit_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy
);
  import logic_arb_pkg::*;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_id_q, rsp_id_d;

  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] lu_result;
  logic             lu_zero;

  // Single shared datapath, always fed from the latched operands.
  logic_unit_32 u_logic_unit (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (lu_result),
    .zero   (lu_zero)
  );

`ifdef LOGIC_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // Winner selection: a lone valid wins; a tie goes to whoever was not granted last.
  always_comb begin
    grant_id = ~req0_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_q;
    end
  end

  // Remember the most recent grant on every accept.
  always_comb begin
    last_d = last_q;
    if (accept) begin
      last_d = grant_id;
    end
  end

  // Last-grant register; resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Winner selection: fixed priority, requester 0 wins any tie.
  always_comb begin
    grant_id = ~req0_valid;
  end
`endif

  // Next-state, operand capture, response capture and handshake outputs.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_id_d     = rsp_id_q;
    accept       = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp_valid    = 1'b0;
    busy         = 1'b1;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          op_d       = grant_id ? req1_op : req0_op;
          a_d        = grant_id ? req1_a  : req0_a;
          b_d        = grant_id ? req1_b  : req0_b;
          id_d       = grant_id;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = lu_result;
        rsp_zero_d   = lu_zero;
        rsp_id_d     = id_q;
        state_d      = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched request and registered response fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= 2'b00;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_id     = rsp_id_q;

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters, for example the integer pipeline and the branch/compare path. The block accepts a request, executes it over a fixed multi-cycle sequence, and returns a tagged result on one response channel. It sits between the requesters and the combinational logic datapath, which it owns exclusively.

## Interface
Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  request 0 accepted this cycle.
- req0_op  in  2  00 AND, 01 OR, 10 XOR, 11 NOR.
- req0_a, req0_b  in  32 each  operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0.
- rsp_valid  out  1  response is available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  32  operation result.
- rsp_zero  out  1  rsp_result == 0.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any reqN_valid is high, the arbiter picks a winner and raises that reqN_ready combinationally in the same cycle.
  - It latches op, a, b and the id, then moves to EXEC.
  - The loser's ready stays 0.
- EXEC:
  - The datapath computes from the latched operands.
  - rsp_result, rsp_zero and rsp_id are registered.
  - Next state is RESP.
- RESP:
  - rsp_valid = 1.
  - The response fields stay stable until rsp_valid && rsp_ready.
  - On that handshake, the next state is IDLE.
- Ready is only asserted in IDLE. Requests arriving in EXEC or RESP wait, and the requester must hold valid and its fields stable.
- A requester must not drop valid before ready. The arbiter does not need to support a withdrawn request.
- NOR = ~(a | b). All ops are bitwise, with no carries and no width growth.
- Reset values: state IDLE, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, busy 0, both ready 0, last-grant register 1.
- Reset mid-operation: the in-flight transaction is discarded and no response is produced.

## Timing
- Request accepted at edge N (valid && ready). rsp_valid goes high after edge N+2 and is visible in cycle N+2.
- If rsp_ready is held high, the handshake completes in cycle N+2 and IDLE is re-entered after edge N+3.
- Peak throughput: one operation per 3 cycles.
- A next request may be accepted in the first IDLE cycle after the response handshake. There is no overlap of response and accept.
- Backpressure: RESP is held indefinitely while rsp_ready is 0, with no field changes.
- Simultaneous valids in IDLE are resolved by the policy in Configuration.
- A single valid always wins, regardless of policy.

## Configuration
- LOGIC_ARB_ROUND_ROBIN_EN:
  - Defined: a round-robin policy. On simultaneous requests, the grant goes to the requester that was not granted last.
  - The last-grant register updates on every accept. Its reset value is 1, so requester 0 wins the first tie.
- Not defined: fixed priority, where requester 0 always wins ties. The last-grant register is not implemented.
- All other behaviour is identical in both builds.

## Structure
- Package logic_arb_pkg holds:
  - op encoding typedef (OP_AND, OP_OR, OP_XOR, OP_NOR, 2 bits);
  - FSM state typedef (IDLE, EXEC, RESP);
  - WIDTH constant.
- Sub-module logic_unit_32: purely combinational, with inputs op, a, b and outputs result, zero. It is instantiated once, fed by the latched operands.
- The arbiter, FSM and response registers live in logic_unit_arbiter.

## Test plan
- Single request: req0 OR with a=0x0000_00F0, b=0x0000_000F, rsp_ready=1. Expect req0_ready in cycle 0, rsp_valid in cycle 2, rsp_result=0x0000_00FF, rsp_id=0, rsp_zero=0.
- All ops, requester 1, with a=0xFFFF_0000 and b=0x0F0F_0F0F:
  - AND gives 0x0F0F_0000.
  - XOR gives 0xF0F0_0F0F.
  - NOR gives 0x0000_F0F0.
  - AND with b=0 gives result 0 and rsp_zero=1.
- Tie with backpressure: both valid continuously, rsp_ready=0 for 5 cycles in RESP. The response fields stay stable, busy=1, and no further ready is raised. After release, the next grant follows the policy.
- Tie sequence, 4 back-to-back ties:
  - With LOGIC_ARB_ROUND_ROBIN_EN, the grant ids are 0,1,0,1.
  - Without it, the grant ids are 0,0,0,0.
- Reset mid-op: assert rst_n=0 asynchronously during EXEC. rsp_valid=0 and busy=0 immediately. After release the block is IDLE with no response, and a new request completes normally.
